// File: rtl/lc3b_types.sv
// Shared LC-3b types: word and line widths, arbiter state encoding and grant bit positions.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int unsigned LINE_OFFSET_W = 4;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned GRANT_I = 0;
    localparam int unsigned GRANT_D = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    function automatic lc3b_word line_align(input lc3b_word addr);
        return addr & ~lc3b_word'((1 << LINE_OFFSET_W) - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and physical-memory bus of the memory arbiter; slave is the arbiter's view.
interface mem_arbiter_if;
    import lc3b_types::*;

    // Handshake: a requester raises read/write and holds it with a stable address
    // until its resp pulse; resp qualifies rdata for exactly that one cycle.
    // Physical memory sees a strobe held until its own one-cycle pmem_resp.
    logic     mem1_read;
    lc3b_word mem1_address;
    lc3b_line mem1_rdata;
    logic     mem1_resp;

    logic     mem2_read;
    logic     mem2_write;
    lc3b_word mem2_address;
    lc3b_line mem2_wdata;
    lc3b_line mem2_rdata;
    logic     mem2_resp;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;

    modport slave (
        input  mem1_read, mem1_address,
        output mem1_rdata, mem1_resp,
        input  mem2_read, mem2_write, mem2_address, mem2_wdata,
        output mem2_rdata, mem2_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem1_read, mem1_address,
        input  mem1_rdata, mem1_resp,
        output mem2_read, mem2_write, mem2_address, mem2_wdata,
        input  mem2_rdata, mem2_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/arb_select.sv
// Grant policy for the memory arbiter: fixed data-side priority, or round-robin
// on ties when MEM_ARBITER_RR_EN is defined.
module arb_select
    import lc3b_types::*;
(
    input  logic       req_inst,
    input  logic       req_data,
`ifdef MEM_ARBITER_RR_EN
    input  logic       last_data,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_inst && req_data) begin
`ifdef MEM_ARBITER_RR_EN
            // A tie goes to whichever side was not served last.
            grant[GRANT_I] = last_data;
            grant[GRANT_D] = ~last_data;
`else
            grant[GRANT_D] = 1'b1;
`endif
        end else if (req_data) begin
            grant[GRANT_D] = 1'b1;
        end else if (req_inst) begin
            grant[GRANT_I] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sequential arbiter sharing one physical-memory port between instruction fetch (mem1)
// and the data stage (mem2). MEM_ARBITER_RR_EN selects round-robin tie breaking.
module mem_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus,
    output arb_state_t    dbg_state
);

    arb_state_t state_q, state_d;
    lc3b_word   addr_q;
    lc3b_line   wdata_q;
    logic       write_q;
    logic [1:0] grant;

`ifdef MEM_ARBITER_RR_EN
    logic       last_data_q;
`endif

    arb_select u_select (
        .req_inst  (bus.mem1_read),
        .req_data  (bus.mem2_read | bus.mem2_write),
`ifdef MEM_ARBITER_RR_EN
        .last_data (last_data_q),
`endif
        .grant     (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The winning request is captured once so that pmem sees stable values
    // even if the requester changes or drops its inputs mid-service.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_data_q <= 1'b0;
`endif
        end else if (state_q == IDLE && grant != 2'b00) begin
            if (grant[GRANT_D]) begin
                addr_q  <= line_align(bus.mem2_address);
                wdata_q <= bus.mem2_wdata;
                write_q <= bus.mem2_write;
            end else begin
                addr_q  <= line_align(bus.mem1_address);
                write_q <= 1'b0;
            end
`ifdef MEM_ARBITER_RR_EN
            last_data_q <= grant[GRANT_D];
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.mem1_resp  = 1'b0;
        bus.mem2_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant[GRANT_D]) begin
                    state_d = SERVE_D;
                end else if (grant[GRANT_I]) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.mem1_resp = 1'b1;
                    state_d       = IDLE;
                end
            end
            SERVE_D: begin
                // Read and write together were latched as a write.
                bus.pmem_read  = ~write_q;
                bus.pmem_write = write_q;
                if (bus.pmem_resp) begin
                    bus.mem2_resp = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.mem1_rdata   = bus.pmem_rdata;
    assign bus.mem2_rdata   = bus.pmem_rdata;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  arb_state_t dbg_state;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit       dside;
    bit       wr;
    lc3b_word addr;
    lc3b_line wdata;
    lc3b_line rdata;
    int       delay;
    lc3b_word exp_addr;
  } vec_t;

  vec_t vecs[5];

  localparam lc3b_line LINE_DEADBEEF = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0011_2233, 16'hBEEF};
  localparam lc3b_line LINE_A5 = {16{8'hA5}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic init_bus();
    bus.mem1_read    = 1'b0;
    bus.mem1_address = '0;
    bus.mem2_read    = 1'b0;
    bus.mem2_write   = 1'b0;
    bus.mem2_address = '0;
    bus.mem2_wdata   = '0;
    bus.pmem_rdata   = '0;
    bus.pmem_resp    = 1'b0;
  endtask

  task automatic drop_reqs();
    bus.mem1_read  = 1'b0;
    bus.mem2_read  = 1'b0;
    bus.mem2_write = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_strobe"}, 128'({bus.pmem_write, bus.pmem_read}), 128'(2'b00));
    check({tag, "_idle_resp"}, 128'({bus.mem2_resp, bus.mem1_resp}), 128'(2'b00));
    check({tag, "_idle_state"}, 128'(dbg_state), 128'(IDLE));
  endtask

  // Bounded wait for a pmem strobe; lat = negedges waited, -1 on timeout.
  task automatic wait_strobe(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.pmem_read || bus.pmem_write) return;
    end
    lat = -1;
  endtask

  // Expects one pmem transaction for the given side, answers it after 'delay'
  // cycles, checks the resp routing, and returns at posedge+1 after the resp edge.
  task automatic serve(input bit dside, input bit wr, input lc3b_word exp_addr,
                       input lc3b_line exp_wdata, input lc3b_line rdata,
                       input int delay, input int exp_lat, input string tag);
    int lat;
    wait_strobe(lat);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_state"}, 128'(dbg_state), 128'(dside ? SERVE_D : SERVE_I));
    check({tag, "_strobe"}, 128'({bus.pmem_write, bus.pmem_read}), 128'(wr ? 2'b10 : 2'b01));
    check({tag, "_addr"}, 128'(bus.pmem_address), 128'(exp_addr));
    if (wr) check({tag, "_wdata"}, bus.pmem_wdata, exp_wdata);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check({tag, "_hold_strobe"}, 128'({bus.pmem_write, bus.pmem_read}), 128'(wr ? 2'b10 : 2'b01));
      check({tag, "_hold_addr"}, 128'(bus.pmem_address), 128'(exp_addr));
      check({tag, "_early_resp"}, 128'({bus.mem2_resp, bus.mem1_resp}), 128'(2'b00));
    end
    bus.pmem_rdata = rdata;
    bus.pmem_resp  = 1'b1;
    #1;
    check({tag, "_resp"}, 128'({bus.mem2_resp, bus.mem1_resp}), 128'(dside ? 2'b10 : 2'b01));
    check({tag, "_rdata"}, dside ? bus.mem2_rdata : bus.mem1_rdata, rdata);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
  endtask

  function automatic bit pick_data(input bit r1, input bit r2, input bit last_d);
    if (r1 && r2) begin
`ifdef MEM_ARBITER_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return r2;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    bit act, gap, gap_next, act_d, act_wr, last_d, done1, done2, just1, just2, pd;
    lc3b_word act_addr, s_a1, s_a2;
    lc3b_line act_wdata, s_wd2;
    bit s_r1, s_r2, s_w2;
    int cnt, op;

    vecs[0] = '{dside: 1'b0, wr: 1'b0, addr: 16'h1236, wdata: '0, rdata: LINE_DEADBEEF, delay: 3, exp_addr: 16'h1230};
    vecs[1] = '{dside: 1'b1, wr: 1'b1, addr: 16'h4008, wdata: LINE_A5, rdata: '0, delay: 1, exp_addr: 16'h4000};
    vecs[2] = '{dside: 1'b1, wr: 1'b0, addr: 16'hFFFF, wdata: '0, rdata: {8{16'h5A3C}}, delay: 0, exp_addr: 16'hFFF0};
    vecs[3] = '{dside: 1'b0, wr: 1'b0, addr: 16'h000F, wdata: '0, rdata: {4{32'hCAFE_F00D}}, delay: 0, exp_addr: 16'h0000};
    vecs[4] = '{dside: 1'b1, wr: 1'b1, addr: 16'h7FF1, wdata: {4{32'h1357_9BDF}}, rdata: '0, delay: 2, exp_addr: 16'h7FF0};

    // Reset state.
    init_bus();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_strobe", 128'({bus.pmem_write, bus.pmem_read}), 128'(2'b00));
    check("rst_resp", 128'({bus.mem2_resp, bus.mem1_resp}), 128'(2'b00));
    check("rst_addr", 128'(bus.pmem_address), 128'(16'h0000));
    check("rst_wdata", bus.pmem_wdata, '0);
    check("rst_state", 128'(dbg_state), 128'(IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single transactions from the vector table.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (vecs[i].dside) begin
        bus.mem2_address = vecs[i].addr;
        bus.mem2_wdata   = vecs[i].wdata;
        bus.mem2_write   = vecs[i].wr;
        bus.mem2_read    = !vecs[i].wr;
      end else begin
        bus.mem1_address = vecs[i].addr;
        bus.mem1_read    = 1'b1;
      end
      serve(vecs[i].dside, vecs[i].wr, vecs[i].exp_addr, vecs[i].wdata, vecs[i].rdata,
            vecs[i].delay, 2, $sformatf("vec%0d", i));
      drop_reqs();
      idle_check($sformatf("vec%0d", i));
    end

    // Address and data change while SERVE_D is in progress.
    @(posedge clk); #1;
    bus.mem2_address = 16'h4008;
    bus.mem2_wdata   = LINE_A5;
    bus.mem2_write   = 1'b1;
    wait_strobe(lat);
    check("chg_latency", 128'(lat), 128'(2));
    @(posedge clk); #1;
    bus.mem2_address = 16'h8000;
    bus.mem2_wdata   = '0;
    repeat (2) begin
      @(negedge clk);
      check("chg_addr", 128'(bus.pmem_address), 128'(16'h4000));
      check("chg_wdata", bus.pmem_wdata, LINE_A5);
      check("chg_strobe", 128'({bus.pmem_write, bus.pmem_read}), 128'(2'b10));
    end
    bus.pmem_resp = 1'b1;
    #1;
    check("chg_resp", 128'({bus.mem2_resp, bus.mem1_resp}), 128'(2'b10));
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    drop_reqs();
    idle_check("chg");

    // Reset pulse during SERVE_I abandons the fetch.
    @(posedge clk); #1;
    bus.mem1_address = 16'h2222;
    bus.mem1_read    = 1'b1;
    wait_strobe(lat);
    check("rsv_latency", 128'(lat), 128'(2));
    #2;
    reset_n = 1'b0;
    #1;
    check("rsv_async_read", 128'(bus.pmem_read), 128'(1'b0));
    check("rsv_async_state", 128'(dbg_state), 128'(IDLE));
    check("rsv_async_addr", 128'(bus.pmem_address), 128'(16'h0000));
    bus.pmem_resp = 1'b1;
    #1;
    check("rsv_no_resp", 128'({bus.mem2_resp, bus.mem1_resp}), 128'(2'b00));
    @(posedge clk); #1;
    check("rsv_held_state", 128'(dbg_state), 128'(IDLE));
    bus.pmem_resp = 1'b0;
    bus.mem1_read = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.mem1_address = 16'h3004;
    bus.mem1_read    = 1'b1;
    serve(1'b0, 1'b0, 16'h3000, '0, {4{32'h0BAD_F00D}}, 1, 2, "post_rst");
    drop_reqs();
    idle_check("post_rst");

    // pmem_resp while IDLE is ignored.
    @(posedge clk); #1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {4{32'h7777_1111}};
    @(negedge clk);
    check("idle_resp_out", 128'({bus.mem2_resp, bus.mem1_resp}), 128'(2'b00));
    check("idle_resp_state", 128'(dbg_state), 128'(IDLE));
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    idle_check("idle_resp");

    // Simultaneous requests; mem2 keeps requesting after its first completion.
    pulse_reset();
    @(posedge clk); #1;
    bus.mem1_address = 16'h1100;
    bus.mem1_read    = 1'b1;
    bus.mem2_address = 16'h2208;
    bus.mem2_read    = 1'b1;
    serve(1'b1, 1'b0, 16'h2200, '0, {4{32'h2222_0001}}, 1, 2, "tie1");
    bus.mem2_address = 16'h3300;
    idle_check("tie1");
`ifdef MEM_ARBITER_RR_EN
    serve(1'b0, 1'b0, 16'h1100, '0, {4{32'h1111_0002}}, 0, 1, "tie2");
    bus.mem1_read = 1'b0;
    idle_check("tie2");
    serve(1'b1, 1'b0, 16'h3300, '0, {4{32'h3333_0003}}, 0, 1, "tie3");
    bus.mem2_read = 1'b0;
    idle_check("tie3");
`else
    serve(1'b1, 1'b0, 16'h3300, '0, {4{32'h3333_0003}}, 0, 1, "tie2");
    bus.mem2_read = 1'b0;
    idle_check("tie2");
    serve(1'b0, 1'b0, 16'h1100, '0, {4{32'h1111_0002}}, 0, 1, "tie3");
    bus.mem1_read = 1'b0;
    idle_check("tie3");
`endif

    // Randomized traffic against the transaction-level model.
    init_bus();
    pulse_reset();
    act = 0; gap = 0; last_d = 0; done1 = 0; done2 = 0; cnt = -1;
    act_d = 0; act_wr = 0; act_addr = '0; act_wdata = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk); #1;
      s_r1  = bus.mem1_read;
      s_a1  = bus.mem1_address;
      s_r2  = bus.mem2_read | bus.mem2_write;
      s_w2  = bus.mem2_write;
      s_a2  = bus.mem2_address;
      s_wd2 = bus.mem2_wdata;
      just1 = done1;
      just2 = done2;
      if (done1) begin bus.mem1_read = 1'b0; done1 = 0; end
      if (done2) begin bus.mem2_read = 1'b0; bus.mem2_write = 1'b0; done2 = 0; end
      if (!bus.mem1_read && !just1 && $urandom_range(0, 2) == 0) begin
        bus.mem1_address = 16'($urandom);
        bus.mem1_read    = 1'b1;
      end
      if (!(bus.mem2_read || bus.mem2_write) && !just2 && $urandom_range(0, 2) == 0) begin
        op = int'($urandom_range(0, 3));
        bus.mem2_address = 16'($urandom);
        bus.mem2_wdata   = {$urandom, $urandom, $urandom, $urandom};
        bus.mem2_read    = (op != 2);
        bus.mem2_write   = (op >= 2);
      end
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        if (cnt < 0) cnt = int'($urandom_range(0, 3));
        if (cnt == 0) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
          cnt = -1;
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end

      @(negedge clk);
      gap_next = 0;
      if (!act && !gap && (s_r1 || s_r2)) begin
        pd        = pick_data(s_r1, s_r2, last_d);
        act_d     = pd;
        act_wr    = pd && s_w2;
        act_addr  = pd ? {s_a2[15:4], 4'h0} : {s_a1[15:4], 4'h0};
        act_wdata = s_wd2;
        check("rnd_start_strobe", 128'({bus.pmem_write, bus.pmem_read}), 128'(act_wr ? 2'b10 : 2'b01));
        check("rnd_start_addr", 128'(bus.pmem_address), 128'(act_addr));
        if (act_wr) check("rnd_start_wdata", bus.pmem_wdata, act_wdata);
        act    = 1;
        last_d = pd;
      end else if (act) begin
        check("rnd_hold_strobe", 128'({bus.pmem_write, bus.pmem_read}), 128'(act_wr ? 2'b10 : 2'b01));
        check("rnd_hold_addr", 128'(bus.pmem_address), 128'(act_addr));
      end else begin
        check("rnd_idle_strobe", 128'({bus.pmem_write, bus.pmem_read}), 128'(2'b00));
      end
      if (act && bus.pmem_resp) begin
        check("rnd_resp", 128'({bus.mem2_resp, bus.mem1_resp}), 128'(act_d ? 2'b10 : 2'b01));
        check("rnd_rdata", act_d ? bus.mem2_rdata : bus.mem1_rdata, bus.pmem_rdata);
        if (act_d) done2 = 1; else done1 = 1;
        act      = 0;
        gap_next = 1;
      end else begin
        check("rnd_no_resp", 128'({bus.mem2_resp, bus.mem1_resp}), 128'(2'b00));
      end
      gap = gap_next;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing the single physical-memory port between the pipeline's instruction-fetch requester (mem1, read-only) and the MEM-stage data requester (mem2, read/write). It sits between the two requester ports and physical memory. It latches one whole-line transaction at a time, drives it to physical memory, and routes the response back to the requester that owns it. It serialises simultaneous requests, using either fixed data-side priority or round-robin.

## Interface
- No parameters. Widths are fixed: 16-bit word address and 128-bit line.
- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem1_read  in  1  instruction-side line read request; level, held until mem1_resp
- mem1_address  in  16  instruction-side byte address
- mem1_rdata  out  128  instruction-side read line
- mem1_resp  out  1  instruction-side completion, one-cycle pulse
- mem2_read  in  1  data-side line read request
- mem2_write  in  1  data-side line write request
- mem2_address  in  16  data-side byte address
- mem2_wdata  in  128  data-side write line
- mem2_rdata  out  128  data-side read line
- mem2_resp  out  1  data-side completion, one-cycle pulse
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_address  out  16  line-aligned address; bits [3:0] are always 0
- pmem_wdata  out  128  physical memory write line
- pmem_rdata  in  128  physical memory read line
- pmem_resp  in  1  physical memory completion, one-cycle pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: if any request is pending, pick a winner and latch its address, with [3:0] forced to 0.
  - For a data-side winner, also latch the operation (read or write) and mem2_wdata.
  - Enter SERVE_I or SERVE_D on the next edge.
- With no request pending, IDLE stays in IDLE.
- SERVE_x drives these from the latched registers, not from live inputs:
  - pmem_read or pmem_write
  - pmem_address
  - pmem_wdata
- On pmem_resp in SERVE_x:
  - pulse x_resp in the same cycle;
  - pass pmem_rdata through to x_rdata;
  - return to IDLE.
- The mandatory IDLE cycle after each transaction lets the requester deassert its request before the next pick.
- mem2_read and mem2_write asserted together: treated as a write. Illegal for the requester.
- A requester dropping its request mid-service does not abort the transaction. It completes and the resp pulse still fires.
- pmem_resp in IDLE is ignored.
- mem1_rdata and mem2_rdata always mirror pmem_rdata. Only the resp pulse qualifies them.
- Fixed priority (default): the data side wins any simultaneous request. The older instruction in MEM must not be blocked by fetch.

## Timing
- Request first visible at edge 0 in IDLE: pmem strobe asserted after edge 1.
- Minimum latency from request to resp is 2 cycles, when pmem_resp arrives in the first SERVE cycle.
- Back-to-back transactions need at least one IDLE cycle between them.
- Reset (reset_n low, any time, including mid-transaction):
  - state returns to IDLE immediately;
  - pmem_read, pmem_write, mem1_resp and mem2_resp drop to 0 without waiting for a clock;
  - latched address and data go to 0;
  - the round-robin pointer goes to point at the instruction side, so the data side wins the first tie.
- An in-flight physical-memory transaction at reset is abandoned. Physical memory must tolerate a dropped strobe.

## Configuration
- MEM_ARBITER_RR_EN defined:
  - a 1-bit last-grant register records the side most recently served;
  - on a simultaneous request in IDLE, the other side wins;
  - the register updates on entry to SERVE_x.
- Not defined:
  - fixed data-side priority;
  - no last-grant register;
  - the instruction side can starve while data requests continue back-to-back.

## Structure
- The shared lc3b_types package holds:
  - lc3b_word (16 bits);
  - lc3b_line (128 bits);
  - the enum for IDLE, SERVE_I and SERVE_D;
  - a constant for the line offset width (4).
- One combinational sub-module, arb_select, is natural:
  - inputs: the two request bits and, under the macro, the last-grant bit;
  - output: a one-hot grant.
- arb_select keeps the priority policy isolated from the FSM.

## Test plan
- mem1_read alone at 0x1236, pmem_resp 3 cycles after the strobe:
  - pmem_read asserted with pmem_address 0x1230;
  - mem1_resp pulses once with the line 0xDEAD…BEEF;
  - mem2_resp stays 0.
- mem2_write alone at 0x4008 with wdata 0xA5…A5:
  - pmem_write asserted with address 0x4000 and wdata 0xA5…A5;
  - mem2_resp pulses once;
  - pmem_read is never asserted.
- mem1_read and mem2_read raised in the same cycle, held until each resp:
  - without the macro, data is served first, then instruction after one IDLE cycle;
  - with MEM_ARBITER_RR_EN, the same applies on the first tie, and a repeated tie goes to the instruction side first.
- mem2_address changes to 0x8000 mid-SERVE_D:
  - pmem_address holds the latched 0x4000 until pmem_resp.
- reset_n pulsed low for 1 cycle during SERVE_I:
  - pmem_read falls asynchronously and state is IDLE;
  - no mem1_resp for the abandoned transaction;
  - a new request is served normally afterwards.
- pmem_resp pulsed while in IDLE:
  - no resp output and no state change.
